timer_arbiter: RTL and testbench
================================

TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, sets the number of requesters (2..8).
REQ-002 Parameter TICKS_PER_SEC, default 100_000_000, sets the clk cycles per one-second tick.
REQ-003 Parameter SEC_W, default 4, sets the width of one seconds field.
REQ-004 Port clk  input  1  is the system clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n  input  1  is the reset; it SHALL be asynchronous and active-low.
REQ-006 Port req  input  NUM_REQ  is a per-requester level request, held until done or withdrawn.
REQ-007 Port req_secs  input  NUM_REQ*SEC_W  holds the interval length in seconds; field i occupies bits [i*SEC_W +: SEC_W].
REQ-008 Port abort  input  1  is a global synchronous cancel of the running interval.
REQ-009 Port grant  output  NUM_REQ  is the one-hot owner of the timer, held from LOAD through RUN.
REQ-010 Port done  output  NUM_REQ  is a one-cycle completion pulse to the owner.
REQ-011 Port busy  output  1  is high in every state except IDLE.
REQ-012 Port remaining  output  SEC_W  gives the seconds left in the current interval.
REQ-013 Port flash  output  1  is a 1 Hz blink indicator while an interval runs.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RUN, DONE, encoded in 2 bits.
REQ-015 In IDLE with any req bit high, the block SHALL select a winner round-robin, searching from last_owner+1 with wrap; it moves to LOAD on the next edge.
REQ-016 In LOAD:
- grant SHALL become one-hot for the winner.
- remaining SHALL be loaded from that requester's req_secs field.
- The tick counter SHALL be cleared.
- A seconds value of 0 SHALL go directly to DONE; any other value goes to RUN.
REQ-017 In RUN:
- The tick counter (width $clog2(TICKS_PER_SEC)) SHALL increment each cycle.
- At TICKS_PER_SEC-1 the counter wraps to 0, remaining decrements, and flash toggles.
- A wrap with remaining==1 SHALL move the FSM to DONE.
REQ-018 In DONE:
- done SHALL pulse for exactly one cycle on the owner's bit.
- grant SHALL clear in the same cycle.
- last_owner SHALL update to the owner.
- The FSM SHALL return to IDLE.
REQ-019 Latency: the first grant SHALL appear 2 cycles after req rises in IDLE, and done SHALL arrive secs*TICKS_PER_SEC+1 cycles after grant rises.
REQ-020 If the owner's req drops, or abort is high, during LOAD or RUN:
- The FSM SHALL go to IDLE on the next edge.
- No done pulse SHALL be issued.
- grant SHALL clear and last_owner SHALL update to that owner.
REQ-021 Requests arriving while busy SHALL wait; a new arbitration SHALL occur only from IDLE.
REQ-022 Changes to req_secs after LOAD SHALL NOT affect the running interval.
REQ-023 flash SHALL be forced to 0 in IDLE, LOAD and DONE.
REQ-024 When abort is high in IDLE, the block SHALL NOT start an arbitration.

Reset
REQ-025 When rst_n is low, the block SHALL immediately set:
- state to IDLE.
- grant, done, remaining, flash and busy to 0.
- the tick counter to 0.
- last_owner to NUM_REQ-1, so that requester 0 has first priority.
REQ-026 Reset asserted mid-interval SHALL discard the interval with no done pulse.

Configuration
REQ-027 With macro TIMER_ARBITER_FLASH_EN defined, flash SHALL behave per REQ-017/REQ-023.
REQ-028 With TIMER_ARBITER_FLASH_EN undefined:
- flash SHALL be tied to 0.
- No flash register SHALL be synthesized.

Structure
REQ-029 A shared package timer_arb_pkg SHALL hold the FSM state typedef and the state encoding constants.
REQ-030 The round-robin selector SHALL be a sub-module rr_picker that takes req and last_owner and outputs a one-hot winner and a valid flag.

Verification (bench uses TICKS_PER_SEC=10, NUM_REQ=4, SEC_W=4)
REQ-031 req=0001 with secs0=3 -> grant=0001 at cycle +2, remaining counts 3,2,1, done[0] pulses 31 cycles after grant.
REQ-032 req=1111 with all secs=1 -> grants in order 0001, 0010, 0100, 1000, then 0001 again, each followed by a done pulse.
REQ-033 req=0100 with secs2=0 -> grant for 1 cycle, then done[2] in the next cycle, with flash never high.
REQ-034 secs1=5, req[1] dropped at tick 23 -> FSM returns to IDLE, no done pulse, and the next winner is searched from requester 2.
REQ-035 rst_n low for 1 cycle during RUN -> all outputs read 0 immediately, and the next grant goes to requester 0.
REQ-036 abort pulse during RUN with req=0011 -> no done pulse, followed by re-arbitration to requester 1.

Source files
------------

// File: rtl/timer_arb_pkg.sv
// Shared definitions for the timer arbiter: FSM state type and encodings.
package timer_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_RUN  = 2'd2;
    localparam state_t ST_DONE = 2'd3;

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: scans requesters starting one past last_owner,
// wrapping around, and returns the first asserted one as a one-hot winner.
module rr_picker
    import timer_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int LW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [LW-1:0]      last_owner,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic [LW-1:0] idx;

    // First requester found after last_owner (in wrap order) wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = LW'((int'(last_owner) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Timer arbiter: grants a shared seconds timer to one of NUM_REQ requesters
// in round-robin order, counts the requested interval down and pulses done.
// Optional feature macro: TIMER_ARBITER_FLASH_EN enables the 1 Hz flash
// output; without it flash is tied low and no flash register exists.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter int SEC_W         = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*SEC_W-1:0] req_secs,
    input  logic                     abort,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [SEC_W-1:0]         remaining,
    output logic                     flash
);

    localparam int LW = $clog2(NUM_REQ);
    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_SEC - 1);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] owner_q, owner_d;
    logic [LW-1:0]      last_q, last_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [SEC_W-1:0]   rem_q, rem_d;
    logic [TW-1:0]      tick_q, tick_d;

    logic [NUM_REQ-1:0] pick_winner;
    logic               pick_valid;
    logic [LW-1:0]      owner_idx;
    logic [SEC_W-1:0]   sel_secs;
    logic               cancel;
    logic               tick_wrap;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req        (req),
        .last_owner (last_q),
        .winner     (pick_winner),
        .valid      (pick_valid)
    );

    // Binary index of the current owner, used for last_owner and field select
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q[i]) begin
                owner_idx = LW'(i);
            end
        end
    end

    assign sel_secs  = req_secs[int'(owner_idx)*SEC_W +: SEC_W];
    assign cancel    = abort || ((req & owner_q) == '0);
    assign tick_wrap = (state_q == ST_RUN) && (tick_q == TICK_MAX);

    // Next-state logic for the arbitration / countdown FSM
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = '0;
        rem_d   = rem_q;
        tick_d  = tick_q;
        case (state_q)
            ST_IDLE: begin
                if (!abort && pick_valid) begin
                    owner_d = pick_winner;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rem_d   = '0;
                    last_d  = owner_idx;
                end else begin
                    // req_secs is captured only here, later changes are ignored
                    grant_d = owner_q;
                    rem_d   = sel_secs;
                    tick_d  = '0;
                    state_d = (sel_secs == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rem_d   = '0;
                    tick_d  = '0;
                    last_d  = owner_idx;
                end else if (tick_wrap) begin
                    tick_d = '0;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == SEC_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                done_d  = owner_q;
                grant_d = '0;
                last_d  = owner_idx;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= LW'(NUM_REQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            rem_q   <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            tick_q  <= tick_d;
        end
    end

`ifdef TIMER_ARBITER_FLASH_EN
    logic flash_q;

    // Blink toggles on each second boundary while running, cleared otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flash_q <= 1'b0;
        end else if (state_q != ST_RUN) begin
            flash_q <= 1'b0;
        end else if (tick_wrap && !cancel) begin
            flash_q <= ~flash_q;
        end
    end

    assign flash = flash_q && (state_q == ST_RUN);
`else
    assign flash = 1'b0;
`endif

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);
    assign remaining = rem_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter with TICKS_PER_SEC=10, NUM_REQ=4, SEC_W=4.
module tb_timer_arbiter;

    localparam int NR = 4;
    localparam int SW = 4;
    localparam int TPS = 10;
`ifdef TIMER_ARBITER_FLASH_EN
    localparam logic FL = 1'b1;
`else
    localparam logic FL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*SW-1:0]  req_secs = '0;
    logic              abort = 1'b0;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;
    logic [SW-1:0]     remaining;
    logic              flash;

    int vectors = 0;
    int miscompares = 0;

    timer_arbiter #(
        .NUM_REQ       (NR),
        .TICKS_PER_SEC (TPS),
        .SEC_W         (SW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_secs  (req_secs),
        .abort     (abort),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .remaining (remaining),
        .flash     (flash)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed=%0h expected=%0h", vectors, tag, obs, exp);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".grant"}, 32'(grant), 32'h0);
        chk({tag, ".done"}, 32'(done), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".remaining"}, 32'(remaining), 32'h0);
        chk({tag, ".flash"}, 32'(flash), 32'h0);
    endtask

    initial begin
        // Reset state
        #2;
        chk_idle_zero("reset");
        step(2);
        rst_n = 1'b1;

        // All four requesting, 1 s each: strict round robin from requester 0
        req_secs = 16'h1111;
        req = 4'b1111;
        step(1);
        chk("rr.load_busy", 32'(busy), 32'h1);
        chk("rr.load_grant", 32'(grant), 32'h0);
        step(1);
        for (int k = 0; k < 5; k++) begin
            chk("rr.grant", 32'(grant), 32'(4'b0001 << (k % 4)));
            step(10);
            chk("rr.pre_done", 32'(done), 32'h0);
            step(1);
            chk("rr.done", 32'(done), 32'(4'b0001 << (k % 4)));
            chk("rr.grant_clr", 32'(grant), 32'h0);
            if (k < 4) begin
                step(2);
            end
        end
        req = '0;
        step(1);
        chk("rr.idle_busy", 32'(busy), 32'h0);
        chk("rr.done_clr", 32'(done), 32'h0);

        // Single requester 0, 3 s; req_secs change after load is ignored
        req_secs = 16'h0003;
        req = 4'b0001;
        step(2);
        chk("r0.grant", 32'(grant), 32'h1);
        chk("r0.rem3", 32'(remaining), 32'h3);
        req_secs = 16'h0009;
        step(9);
        chk("r0.rem3_t9", 32'(remaining), 32'h3);
        chk("r0.flash_t9", 32'(flash), 32'h0);
        step(1);
        chk("r0.rem2", 32'(remaining), 32'h2);
        chk("r0.flash_s1", 32'(flash), 32'(FL));
        step(10);
        chk("r0.rem1", 32'(remaining), 32'h1);
        chk("r0.flash_s2", 32'(flash), 32'h0);
        step(10);
        chk("r0.rem0", 32'(remaining), 32'h0);
        chk("r0.grant_held", 32'(grant), 32'h1);
        chk("r0.no_done_yet", 32'(done), 32'h0);
        step(1);
        chk("r0.done_at31", 32'(done), 32'h1);
        chk("r0.grant_clr", 32'(grant), 32'h0);
        chk("r0.busy_clr", 32'(busy), 32'h0);
        req = '0;
        step(1);
        chk("r0.done_1cyc", 32'(done), 32'h0);

        // Zero-second interval on requester 2
        req_secs = 16'h0000;
        req = 4'b0100;
        step(1);
        chk("z2.load_busy", 32'(busy), 32'h1);
        step(1);
        chk("z2.grant", 32'(grant), 32'h4);
        chk("z2.flash_a", 32'(flash), 32'h0);
        chk("z2.no_done", 32'(done), 32'h0);
        step(1);
        chk("z2.done", 32'(done), 32'h4);
        chk("z2.grant_clr", 32'(grant), 32'h0);
        chk("z2.flash_b", 32'(flash), 32'h0);
        req = '0;
        step(1);
        chk("z2.done_clr", 32'(done), 32'h0);

        // Requester 1, 5 s, withdrawn at tick 23
        req_secs = 16'h0050;
        req = 4'b0010;
        step(2);
        chk("wd.grant", 32'(grant), 32'h2);
        chk("wd.rem5", 32'(remaining), 32'h5);
        step(23);
        chk("wd.rem3", 32'(remaining), 32'h3);
        req = '0;
        step(1);
        chk("wd.busy_clr", 32'(busy), 32'h0);
        chk("wd.grant_clr", 32'(grant), 32'h0);
        chk("wd.no_done", 32'(done), 32'h0);
        req_secs = 16'h0000;
        req = 4'b0110;
        step(1);
        chk("wd.no_done2", 32'(done), 32'h0);
        step(1);
        chk("wd.next_from2", 32'(grant), 32'h4);
        step(1);
        chk("wd.done2", 32'(done), 32'h4);
        req = '0;
        step(1);

        // Abort during run with req=0011, then re-arbitration to requester 1
        req_secs = 16'h0003;
        req = 4'b0011;
        step(2);
        chk("ab.grant0", 32'(grant), 32'h1);
        step(5);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("ab.busy_clr", 32'(busy), 32'h0);
        chk("ab.grant_clr", 32'(grant), 32'h0);
        chk("ab.no_done", 32'(done), 32'h0);
        step(1);
        chk("ab.reload_busy", 32'(busy), 32'h1);
        chk("ab.no_done2", 32'(done), 32'h0);
        step(1);
        chk("ab.grant1", 32'(grant), 32'h2);
        step(1);
        chk("ab.done1", 32'(done), 32'h2);
        req = '0;
        step(1);

        // Reset pulse mid-run, then requester 0 has first priority again
        req_secs = 16'h0050;
        req = 4'b0010;
        step(2);
        chk("rs.grant1", 32'(grant), 32'h2);
        step(5);
        rst_n = 1'b0;
        req = '0;
        #1;
        chk_idle_zero("rs.async");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_secs = 16'h0000;
        req = 4'b1001;
        step(1);
        chk("rs.no_done", 32'(done), 32'h0);
        step(1);
        chk("rs.grant0", 32'(grant), 32'h1);
        step(1);
        chk("rs.done0", 32'(done), 32'h1);
        req = '0;
        step(1);

        // Abort held in IDLE blocks arbitration
        req = 4'b0001;
        abort = 1'b1;
        step(2);
        chk("ai.busy", 32'(busy), 32'h0);
        chk("ai.grant", 32'(grant), 32'h0);
        abort = 1'b0;
        step(2);
        chk("ai.grant_after", 32'(grant), 32'h1);
        req = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
